chatter_counter: RTL and testbench

CHATTER_COUNTER -- requirements
Module: chatter_counter

---
 rtl/chatter_counter.sv | 56 +++++
 tb/tb_chatter_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/chatter_counter.sv
// Switch debouncer: two-flop synchronizer, stability counter, and a run/stop flag
// that toggles on every accepted press.
module chatter_counter #(
  parameter int unsigned THRESHOLD = 200
) (
  input  logic       chatterclock,
  input  logic       chatterreset,
  input  logic       switchin,
  output logic       ispressed,
  output logic       enabled,
  output logic [7:0] count
);

  localparam logic [7:0] LastCount = 8'(THRESHOLD - 1);

  logic       sync1_q, sync2_q;
  logic       pressed_q, pressed_d;
  logic       enabled_q, enabled_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    pressed_d = pressed_q;
    enabled_d = enabled_q;
    count_d   = 8'd0;
    if (sync2_q != pressed_q) begin
      // The >= guards against ever running past the last count.
      if (count_q >= LastCount) begin
        pressed_d = sync2_q;
        enabled_d = enabled_q ^ sync2_q;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge chatterclock) begin
    if (chatterreset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      pressed_q <= 1'b0;
      enabled_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= switchin;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      enabled_q <= enabled_d;
      count_q   <= count_d;
    end
  end

  assign ispressed = pressed_q;
  assign enabled   = enabled_q;
  assign count     = count_q;

endmodule

// File: tb/tb_chatter_counter.sv
// Randomized and directed bench for chatter_counter with a run-length reference model
// feeding a scoreboard queue that a negedge monitor drains.
module tb_chatter_counter;

  localparam int unsigned Thr = 4;

  logic       chatterclock = 1'b0;
  logic       chatterreset = 1'b1;
  logic       switchin     = 1'b0;
  logic       ispressed;
  logic       enabled;
  logic [7:0] count;

  chatter_counter #(.THRESHOLD(Thr)) dut (
    .chatterclock(chatterclock),
    .chatterreset(chatterreset),
    .switchin    (switchin),
    .ispressed   (ispressed),
    .enabled     (enabled),
    .count       (count)
  );

  always #5 chatterclock = ~chatterclock;

  typedef struct {
    logic pressed;
    logic en;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a two-sample delay line, then a run-length of disagreeing samples.
  logic pipe[$];
  logic m_pressed;
  logic m_enabled;
  int   m_run;

  task automatic model_edge(input logic rst, input logic sw);
    logic s;
    exp_t e;
    if (rst) begin
      pipe.delete();
      pipe.push_back(1'b0);
      pipe.push_back(1'b0);
      m_pressed = 1'b0;
      m_enabled = 1'b0;
      m_run     = 0;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(sw);
      if (s == m_pressed) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == Thr) begin
          m_pressed = s;
          m_run     = 0;
          if (s) m_enabled = ~m_enabled;
        end
      end
    end
    e.pressed = m_pressed;
    e.en      = m_enabled;
    e.cnt     = m_run;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic sw);
    chatterreset = rst;
    switchin     = sw;
    model_edge(rst, sw);
    @(posedge chatterclock);
    #1;
  endtask

  task automatic hold(input logic sw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, sw);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge chatterclock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ispressed", int'(ispressed), int'(e.pressed));
      check("enabled", int'(enabled), int'(e.en));
      check("count", int'(count), e.cnt);
    end
  end

  initial begin
    int waited;
    // Reset, then a quiet line.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 8);
    // Reset, then a held press.
    step(1'b1, 1'b1);
    hold(1'b1, 12);
    // Short release bounce from the pressed state.
    hold(1'b0, 2);
    hold(1'b1, 10);
    // Two clean release/press cycles.
    for (int c = 0; c < 2; c++) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
    end
    // Reset mid-count, then re-qualify with switch held high.
    hold(1'b0, 10);
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    hold(1'b1, 10);
    // Repeated sub-threshold bounces.
    for (int r = 0; r < 5; r++) begin
      hold(1'b0, 3);
      hold(1'b1, 1);
    end
    hold(1'b1, 6);
    // Bursty random levels around the threshold, with occasional resets.
    for (int b = 0; b < 150; b++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * Thr + 2));
      if ($urandom_range(0, 29) == 0) step(1'b1, lvl);
      hold(lvl, len);
    end
    chatterreset = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge chatterclock);
      waited++;
    end
    @(posedge chatterclock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
